// File: rtl/button_counter_pkg.sv
// Shared types and defaults for the debounced up/down button counter.
package button_counter_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } deb_state_t;

    typedef logic [3:0]  count_t;
    typedef logic [15:0] deb_cnt_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int MAX_VALUE_DEFAULT       = 15;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, optional debounce FSM when
// BUTTON_COUNTER_DEBOUNCE_EN is defined; otherwise level = sync output.
module button_debouncer
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    logic [1:0] sync_q;
    logic       sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    assign sync = sync_q[1];

`ifdef BUTTON_COUNTER_DEBOUNCE_EN

    // The sample that leaves a stable state is the first of the run,
    // so the check state needs DEBOUNCE_CYCLES-1 more matching samples.
    localparam deb_cnt_t LAST = deb_cnt_t'(DEBOUNCE_CYCLES - 2);

    deb_state_t state_q, state_d;
    deb_cnt_t   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (sync) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        level = 1'b0;
        if (state_q == STABLE_HIGH || state_q == CHECK_LOW) begin
            level = 1'b1;
        end
    end

`else

    assign level = sync;

`endif

endmodule

// File: rtl/button_counter.sv
// Up/down count driven by two filtered buttons; wraps 0..MAX_VALUE.
// Debounce filtering is enabled by BUTTON_COUNTER_DEBOUNCE_EN.
module button_counter
    import button_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int MAX_VALUE       = MAX_VALUE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       enable,
    output logic [3:0] bcd_output,
    output logic       wrap
);

    localparam count_t MAX = count_t'(MAX_VALUE);

    logic   level_inc, level_dec;
    logic   hist_inc_q, hist_dec_q;
    logic   inc_p, dec_p;
    logic   inc_only, dec_only;
    count_t count_q, count_d;
    logic   wrap_q, wrap_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_inc (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_inc),
        .level(level_inc)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_dec (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_dec),
        .level(level_dec)
    );

    // History updates regardless of enable so a held press is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_inc_q <= 1'b0;
            hist_dec_q <= 1'b0;
        end else begin
            hist_inc_q <= level_inc;
            hist_dec_q <= level_dec;
        end
    end

    assign inc_p    = level_inc & ~hist_inc_q;
    assign dec_p    = level_dec & ~hist_dec_q;
    assign inc_only = enable & inc_p & ~dec_p;
    assign dec_only = enable & dec_p & ~inc_p;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        unique case (1'b1)
            inc_only: begin
                if (count_q >= MAX) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            dec_only: begin
                if (count_q == '0) begin
                    count_d = MAX;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: begin
                count_d = count_q;
                wrap_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bcd_output = count_q;
    assign wrap       = wrap_q;

endmodule

// File: doc/button_counter.md
BUTTON_COUNTER -- requirements
Module: button_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable clk cycles required to accept a new button level (range 2..65535).
REQ-002 Parameter MAX_VALUE, default 15, upper count limit (range 1..15).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-005 btn_inc  input  1  raw asynchronous increment button, active-high.
REQ-006 btn_dec  input  1  raw asynchronous decrement button, active-high.
REQ-007 enable  input  1  synchronous; when 0, accepted presses are discarded.
REQ-008 bcd_output  output  4  current count, drives the seven-segment decoder's 4-bit bcd_input directly.
REQ-009 wrap  output  1  one-cycle pulse when count wraps in either direction.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 A press SHALL be a 0->1 transition of the filtered (synchronized, optionally debounced) button level; each press yields exactly one single-cycle press pulse, regardless of hold duration.
REQ-012 On an inc pulse with enable=1, bcd_output SHALL become bcd_output+1, or 0 with wrap=1 when bcd_output==MAX_VALUE.
REQ-013 On a dec pulse with enable=1, bcd_output SHALL become bcd_output-1, or MAX_VALUE with wrap=1 when bcd_output==0.
REQ-014 Inc and dec pulses in the same cycle SHALL leave bcd_output unchanged and wrap=0.
REQ-015 With enable=0, press pulses SHALL be dropped (not queued); bcd_output holds.
REQ-016 wrap SHALL be registered, high only in the cycle bcd_output shows the wrapped value.
REQ-017 bcd_output SHALL be a register output; it SHALL never exceed MAX_VALUE.
REQ-018 Debouncer FSM per button, states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW; STABLE_LOW->CHECK_HIGH on sync=1; CHECK_HIGH->STABLE_HIGH after DEBOUNCE_CYCLES consecutive sync=1, ->STABLE_LOW on any sync=0; symmetric for STABLE_HIGH/CHECK_LOW; filtered level = 1 in STABLE_HIGH and CHECK_LOW.
REQ-019 Debounce counter SHALL clear on every state change and SHALL not wrap.

Reset
REQ-020 While rst=1: bcd_output=0, wrap=0, synchronizer flops=0, debouncer FSMs=STABLE_LOW with counter=0, edge-detect history=0.
REQ-021 Reset asserted mid-debounce or mid-press SHALL abort it; a button still held after reset release SHALL produce one press once it passes the filter.

Configuration
REQ-022 Macro BUTTON_COUNTER_DEBOUNCE_EN: defined -> debouncer FSM instantiated per REQ-018; count updates on the edge DEBOUNCE_CYCLES+3 cycles after raw input rises (clean input).
REQ-023 Macro undefined -> debouncer omitted, DEBOUNCE_CYCLES ignored, filtered level = synchronizer output; count updates on the 3rd rising clk edge after raw input rises.

Structure
REQ-024 Package button_counter_pkg SHALL hold the debounce state enum typedef, the 4-bit count typedef and the DEBOUNCE_CYCLES/MAX_VALUE default constants.
REQ-025 Sub-module button_debouncer (synchronizer + FSM + counter, one button) SHALL be instantiated twice; the top holds edge detect, count register and wrap logic.

Verification
REQ-026 rst=1 2 cycles, release -> bcd_output=0, wrap=0.
REQ-027 16 clean btn_inc presses (held 40 cycles, released 40, DEBOUNCE_CYCLES=16) -> bcd_output steps 1..15 then 0, wrap=1 on the 16th only.
REQ-028 From 0, one btn_dec press -> bcd_output=15, wrap=1 one cycle; MAX_VALUE=9 run -> 0 dec gives 9.
REQ-029 btn_inc bouncing 0/1 every 3 cycles for 30 cycles then stable 1 -> exactly one increment (macro defined); macro undefined -> one increment per bounce rising edge.
REQ-030 btn_inc and btn_dec rising in the same cycle -> bcd_output unchanged, wrap=0; press with enable=0 -> no change, and raising enable afterward while still held -> no change.
REQ-031 rst pulsed during CHECK_HIGH at bcd_output=5 -> bcd_output=0, held button yields exactly one increment to 1 after release of rst.
